// File: rtl/ps2_key_event_pkg.sv
// Shared scan-code set-2 constants, FSM state encoding and code classifiers
// for the PS/2 key event decoder.
package ps2_key_event_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Pause/Break sends E1 followed by seven more bytes that must be swallowed
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } keyState_t;

    // Keyboard housekeeping replies (ACK, BAT ok, echo, resend, errors) carry no key
    function automatic logic isIgnored(input logic [7:0] code);
        case (code)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: isIgnored = 1'b1;
            default:                                  isIgnored = 1'b0;
        endcase
    endfunction

    // Make codes of the 26 letter keys A..Z; only these are affected by Caps Lock
    function automatic logic isAlpha(input logic [7:0] code);
        case (code)
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A:
                isAlpha = 1'b1;
            default:
                isAlpha = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Idle watchdog for the prefix states: counts cycles with no received byte and
// flags when a half-finished scan-code sequence should be abandoned.
module ps2_prefix_timer #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Count idle cycles, holding at the last value so the counter can never wrap
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_run && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_run && (r_count == LAST);

endmodule

// File: rtl/ps2_key_event.sv
// Scan-code set-2 decoder: turns the PS/2 byte stream into one key event per
// make code, tracking E0/F0/E1 prefixes and the Shift/Caps Lock state.
module ps2_key_event
    import ps2_key_event_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done_tick,
    output logic       o_key_tick,
    output logic [7:0] o_scan_code,
    output logic       o_extended,
    output logic       o_letter_case,
    output logic       o_shift_held,
    output logic       o_caps_on
);

    keyState_t  r_state;
    keyState_t  w_stateNext;
    logic [2:0] r_skipCnt;
    logic [2:0] w_skipNext;
    logic       r_lshift, r_rshift, r_capsDown, r_capsOn, r_shiftHeld;
    logic       w_lshiftNext, w_rshiftNext, w_capsDownNext, w_capsOnNext;
    logic       r_keyTick, r_extended, r_letterCase;
    logic [7:0] r_scanCode;
    logic       w_isMake, w_isBreak, w_ext, w_emit, w_letterCase;
    logic       w_timerClr, w_timerRun, w_expired;

    // A received byte always restarts the watchdog; it only runs mid-sequence
    assign w_timerClr = i_rx_done_tick || (r_state == ST_IDLE);
    assign w_timerRun = (r_state != ST_IDLE) && !i_rx_done_tick;

    ps2_prefix_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_prefixTimer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (w_timerClr),
        .i_run    (w_timerRun),
        .o_expired(w_expired)
    );

    // Next-state decode: classify each byte, then apply make/break effects to the modifiers
    always_comb begin
        w_stateNext    = r_state;
        w_skipNext     = r_skipCnt;
        w_lshiftNext   = r_lshift;
        w_rshiftNext   = r_rshift;
        w_capsDownNext = r_capsDown;
        w_capsOnNext   = r_capsOn;
        w_isMake       = 1'b0;
        w_isBreak      = 1'b0;
        w_ext          = 1'b0;
        w_emit         = 1'b0;

        if (i_rx_done_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_data == SC_BREAK) begin
                        w_stateNext = ST_BRK;
                    end else if (i_rx_data == SC_EXT) begin
                        w_stateNext = ST_EXT;
                    end else if (i_rx_data == SC_PAUSE) begin
                        w_stateNext = ST_PAUSE;
                        w_skipNext  = PAUSE_SKIP;
                    end else if (!isIgnored(i_rx_data)) begin
                        w_isMake = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (i_rx_data == SC_BREAK) begin
                        w_stateNext = ST_EXT_BRK;
                    end else if ((i_rx_data == SC_LSHIFT) || (i_rx_data == SC_RSHIFT)) begin
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_isMake    = 1'b1;
                        w_ext       = 1'b1;
                        w_stateNext = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_isBreak   = 1'b1;
                    w_stateNext = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_isBreak   = 1'b1;
                    w_ext       = 1'b1;
                    w_stateNext = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (r_skipCnt <= 3'd1) begin
                        w_skipNext  = 3'd0;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_skipNext = r_skipCnt - 3'd1;
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                end
            endcase
        end else if (w_expired) begin
            w_stateNext = ST_IDLE;
        end

        if (w_isMake) begin
            if (!w_ext && (i_rx_data == SC_LSHIFT)) begin
                w_lshiftNext = 1'b1;
            end else if (!w_ext && (i_rx_data == SC_RSHIFT)) begin
                w_rshiftNext = 1'b1;
            end else if (!w_ext && (i_rx_data == SC_CAPS)) begin
                if (!r_capsDown) begin
                    w_capsOnNext = !r_capsOn;
                end
                w_capsDownNext = 1'b1;
            end else begin
                w_emit = 1'b1;
            end
        end

        if (w_isBreak && !w_ext) begin
            if (i_rx_data == SC_LSHIFT) begin
                w_lshiftNext = 1'b0;
            end else if (i_rx_data == SC_RSHIFT) begin
                w_rshiftNext = 1'b0;
            end else if (i_rx_data == SC_CAPS) begin
                w_capsDownNext = 1'b0;
            end
        end
    end

    // Case uses the modifier state as it stood before this byte
    assign w_letterCase = r_shiftHeld ^ (r_capsOn && isAlpha(i_rx_data) && !w_ext);

    // FSM, pause skip counter and modifier state registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_skipCnt   <= 3'd0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_capsDown  <= 1'b0;
            r_capsOn    <= 1'b0;
            r_shiftHeld <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_skipCnt   <= w_skipNext;
            r_lshift    <= w_lshiftNext;
            r_rshift    <= w_rshiftNext;
            r_capsDown  <= w_capsDownNext;
            r_capsOn    <= w_capsOnNext;
            r_shiftHeld <= w_lshiftNext || w_rshiftNext;
        end
    end

    // Event outputs: pulse the tick and capture the event, holding it until the next one
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_keyTick    <= 1'b0;
            r_scanCode   <= 8'h00;
            r_extended   <= 1'b0;
            r_letterCase <= 1'b0;
        end else begin
            r_keyTick <= w_emit;
            if (w_emit) begin
                r_scanCode   <= i_rx_data;
                r_extended   <= w_ext;
                r_letterCase <= w_letterCase;
            end
        end
    end

    assign o_key_tick    = r_keyTick;
    assign o_scan_code   = r_scanCode;
    assign o_extended    = r_extended;
    assign o_letter_case = r_letterCase;
    assign o_shift_held  = r_shiftHeld;
    assign o_caps_on     = r_capsOn;

endmodule

// File: tb/tb_ps2_key_event.sv
// Self-checking bench for ps2_key_event: expected key events are queued as bytes
// are sent and compared by a monitor whenever the decoder raises key_tick.
module tb_ps2_key_event;

    localparam int TB_TIMEOUT = 16;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       lc;
        logic       sh;
    } keyEvent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rxData = 8'h00;
    logic       rxDone = 1'b0;
    logic       keyTick;
    logic [7:0] scanCode;
    logic       extended;
    logic       letterCase;
    logic       shiftHeld;
    logic       capsOn;

    keyEvent_t  expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         tickCount = 0;

    ps2_key_event #(
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_rx_data     (rxData),
        .i_rx_done_tick(rxDone),
        .o_key_tick    (keyTick),
        .o_scan_code   (scanCode),
        .o_extended    (extended),
        .o_letter_case (letterCase),
        .o_shift_held  (shiftHeld),
        .o_caps_on     (capsOn)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Scoreboard monitor: every tick must match the oldest outstanding expectation
    always @(negedge clk) begin
        keyEvent_t e;
        if (keyTick === 1'b1) begin
            tickCount++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_tick: got code=%h ext=%b lc=%b sh=%b, required no event",
                         scanCode, extended, letterCase, shiftHeld);
            end else begin
                e = expQ.pop_front();
                if ({scanCode, extended, letterCase, shiftHeld} !== {e.code, e.ext, e.lc, e.sh}) begin
                    errors++;
                    $display("[TB] FAIL event: got code=%h ext=%b lc=%b sh=%b, required code=%h ext=%b lc=%b sh=%b",
                             scanCode, extended, letterCase, shiftHeld, e.code, e.ext, e.lc, e.sh);
                end
            end
        end
    end

    // Present one byte for exactly one cycle; consecutive calls are back-to-back strobes
    task automatic applyStimulus(input logic [7:0] b);
        rxData = b;
        rxDone = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxDone = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectEvent(input logic [7:0] code, input logic ext, input logic lc, input logic sh);
        keyEvent_t e;
        e.code = code;
        e.ext  = ext;
        e.lc   = lc;
        e.sh   = sh;
        expQ.push_back(e);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        checks++;
        if ({keyTick, scanCode, extended, letterCase, shiftHeld, capsOn} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, required all zero",
                     {keyTick, scanCode, extended, letterCase, shiftHeld, capsOn});
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_single_key;
        rxData = 8'h1C;
        rxDone = 1'b1;
        expectEvent(8'h1C, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (keyTick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tick_before_edge: got %b, required 0", keyTick);
        end
        @(posedge clk);
        #1;
        rxDone = 1'b0;
        checks++;
        if (keyTick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tick_latency: got %b, required 1", keyTick);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({keyTick, scanCode} !== {1'b0, 8'h1C}) begin
            errors++;
            $display("[TB] FAIL tick_pulse_hold: got tick=%b code=%h, required tick=0 code=1c",
                     keyTick, scanCode);
        end
        idle(3);
    endtask

    task automatic test_shift;
        int startTicks;
        startTicks = tickCount;
        expectEvent(8'h1C, 1'b0, 1'b1, 1'b1);
        expectEvent(8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h12);
        applyStimulus(8'h1C);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        applyStimulus(8'hF0);
        applyStimulus(8'h12);
        applyStimulus(8'h1C);
        idle(4);
        checks++;
        if (tickCount - startTicks !== 2) begin
            errors++;
            $display("[TB] FAIL shift_tick_count: got %0d, required 2", tickCount - startTicks);
        end
    endtask

    task automatic test_caps;
        expectEvent(8'h1C, 1'b0, 1'b1, 1'b0);
        expectEvent(8'h16, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h58);
        applyStimulus(8'h58);
        applyStimulus(8'hF0);
        applyStimulus(8'h58);
        applyStimulus(8'h1C);
        applyStimulus(8'h16);
        idle(3);
        checks++;
        if (capsOn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL caps_single_toggle: got %b, required 1", capsOn);
        end
        expectEvent(8'h1C, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h12);
        applyStimulus(8'h1C);
        applyStimulus(8'hF0);
        applyStimulus(8'h12);
        applyStimulus(8'h58);
        applyStimulus(8'hF0);
        applyStimulus(8'h58);
        idle(3);
        checks++;
        if ({capsOn, shiftHeld} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL caps_off_shift_released: got caps=%b shift=%b, required 0 0",
                     capsOn, shiftHeld);
        end
    endtask

    task automatic test_extended;
        int startTicks;
        startTicks = tickCount;
        expectEvent(8'h75, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        expectEvent(8'h75, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hE0);
        applyStimulus(8'h12);
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        idle(3);
        checks++;
        if ({tickCount - startTicks, shiftHeld} !== {32'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL ext_ticks_fake_shift: got ticks=%0d shift=%b, required 2 0",
                     tickCount - startTicks, shiftHeld);
        end
    endtask

    task automatic test_pause_ignore;
        int startTicks;
        logic [7:0] pauseSeq[8];
        logic [7:0] ignoreSeq[6];
        pauseSeq  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        ignoreSeq = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        startTicks = tickCount;
        for (int i = 0; i < 8; i++) applyStimulus(pauseSeq[i]);
        expectEvent(8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h1C);
        idle(2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ignoreSeq[i]);
            idle(2);
        end
        idle(2);
        checks++;
        if (tickCount - startTicks !== 1) begin
            errors++;
            $display("[TB] FAIL pause_ignore_ticks: got %0d, required 1", tickCount - startTicks);
        end
    endtask

    task automatic test_back_to_back;
        int startTicks;
        startTicks = tickCount;
        expectEvent(8'h1C, 1'b0, 1'b0, 1'b0);
        expectEvent(8'h32, 1'b0, 1'b0, 1'b0);
        expectEvent(8'h21, 1'b0, 1'b0, 1'b0);
        expectEvent(8'h21, 1'b0, 1'b0, 1'b0);
        expectEvent(8'h1A, 1'b0, 1'b1, 1'b1);
        expectEvent(8'h1A, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h1C);
        applyStimulus(8'h32);
        applyStimulus(8'h21);
        applyStimulus(8'h21);
        applyStimulus(8'h59);
        applyStimulus(8'h1A);
        applyStimulus(8'hF0);
        applyStimulus(8'h59);
        applyStimulus(8'h1A);
        idle(3);
        checks++;
        if (tickCount - startTicks !== 6) begin
            errors++;
            $display("[TB] FAIL back_to_back_ticks: got %0d, required 6", tickCount - startTicks);
        end
    endtask

    task automatic test_timeout;
        expectEvent(8'h75, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hE0);
        idle(TB_TIMEOUT - 1);
        applyStimulus(8'h75);
        expectEvent(8'h75, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hE0);
        idle(TB_TIMEOUT);
        applyStimulus(8'h75);
        expectEvent(8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hE0);
        idle(TB_TIMEOUT + 1);
        applyStimulus(8'h1C);
        expectEvent(8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hF0);
        idle(TB_TIMEOUT + 1);
        applyStimulus(8'h1C);
        idle(3);
        checks++;
        if (expQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL timeout_events_missing: got %0d outstanding, required 0", expQ.size());
        end
    endtask

    task automatic test_reset_mid_sequence;
        applyStimulus(8'h12);
        applyStimulus(8'h58);
        applyStimulus(8'hF0);
        idle(1);
        checks++;
        if ({shiftHeld, capsOn} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL pre_reset_modifiers: got shift=%b caps=%b, required 1 1", shiftHeld, capsOn);
        end
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        checks++;
        if ({shiftHeld, capsOn, scanCode} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: got shift=%b caps=%b code=%h, required 0 0 00",
                     shiftHeld, capsOn, scanCode);
        end
        expectEvent(8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h1C);
        idle(3);
        checks++;
        if (expQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL reset_event_missing: got %0d outstanding, required 0", expQ.size());
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        #1;
        test_reset;
        test_single_key;
        test_shift;
        test_caps;
        test_extended;
        test_pause_ignore;
        test_back_to_back;
        test_timeout;
        test_reset_mid_sequence;
        idle(2);
        checks++;
        if (expQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d outstanding, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
